// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data-memory responder behind the MEM-stage load/store port.
//   A well-formed request seen in IDLE is latched and the pipeline is stalled
//   for exactly LATENCY cycles; the access happens on the last stall edge and
//   the result is presented for one cycle in RESP. Misaligned requests and
//   requests with both read and write set are rejected with an err pulse.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_read     load request
//   req_write    store request
//   req_addr     byte address; word index = req_addr[log2(DEPTH)+1:2]
//   req_wdata    store data
//   stall        hold upstream pipeline registers and PC while high
//   rdata        last read data (held until the next read completes)
//   rdata_valid  one-cycle pulse, rdata updated this cycle
//   wr_done      one-cycle pulse, store committed
//   err          one-cycle pulse, request rejected
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        wr_done,
    output logic        err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam bit         SINGLE   = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          op_write;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH];

    logic          any_req;
    logic          bad_req;
    logic          accept;
    logic          access_now;
    logic          acc_write;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic          unused_addr;

    // Upper address bits only select aliases of the same word.
    assign unused_addr = ^req_addr[31:AW+2];

    assign any_req = req_read | req_write;
    assign bad_req = (req_addr[1:0] != 2'b00) || (req_read && req_write);
    assign accept  = (state == IDLE) && any_req && !bad_req;

    // With a single stall cycle the access coincides with the accept edge and
    // must use the live request; otherwise it uses the latched copy.
    assign access_now = rst_n && ((accept && SINGLE) || (state == WAIT && cnt == 4'd1));

    always_comb begin
        acc_write = op_write;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_write = req_write;
            acc_idx   = req_addr[AW+1:2];
            acc_wdata = req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && any_req && bad_req;
            if (access_now && !acc_write) begin
                rdata_q <= mem[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_write <= req_write;
                        idx_q    <= req_addr[AW+1:2];
                        wdata_q  <= req_wdata;
                        if (SINGLE) begin
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (access_now && acc_write) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Gating with rst_n makes stall fall as soon as reset is asserted, even if
    // a request is still being presented while the state is already IDLE.
    assign stall       = rst_n && (accept || state == WAIT);
    assign rdata       = rdata_q;
    assign rdata_valid = (state == RESP) && !op_write;
    assign wr_done     = (state == RESP) && op_write;
    assign err         = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int NDUT  = 3;
    localparam int DEPTH = 64;

    localparam logic [1:0] K_RD  = 2'd0;
    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rr   [NDUT];
    logic        rw   [NDUT];
    logic [31:0] ra   [NDUT];
    logic [31:0] wd   [NDUT];
    logic        stl  [NDUT];
    logic [31:0] rdat [NDUT];
    logic        rv   [NDUT];
    logic        wdn  [NDUT];
    logic        er   [NDUT];

    int checks = 0;
    int errors = 0;

    exp_t        q    [NDUT][$];
    logic [31:0] mdl  [NDUT][DEPTH];
    logic [31:0] last [NDUT];
    int          lat  [NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: LATENCY 2, dut1: LATENCY 1, dut2: LATENCY 5
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder #(
            .DEPTH  (DEPTH),
            .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 5)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_read   (rr[g]),
            .req_write  (rw[g]),
            .req_addr   (ra[g]),
            .req_wdata  (wd[g]),
            .stall      (stl[g]),
            .rdata      (rdat[g]),
            .rdata_valid(rv[g]),
            .wr_done    (wdn[g]),
            .err        (er[g])
        );
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitors: pop the oldest expected response whenever a DUT pulses.
    for (genvar g = 0; g < NDUT; g++) begin : g_mon
        always @(negedge clk) begin : mon
            exp_t       e;
            logic [1:0] k;
            if (rst_n && (rv[g] || wdn[g] || er[g])) begin
                if (q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse dut%0d: got rv=%0b wr_done=%0b err=%0b expected none",
                             g, rv[g], wdn[g], er[g]);
                end else begin
                    e = q[g].pop_front();
                    k = rv[g] ? K_RD : (wdn[g] ? K_WR : K_ERR);
                    check($sformatf("kind_dut%0d", g), 32'(k), 32'(e.kind));
                    if (rv[g]) begin
                        check($sformatf("rdata_dut%0d", g), rdat[g], e.data);
                        last[g] = e.data;
                    end else begin
                        check($sformatf("rdata_hold_dut%0d", g), rdat[g], last[g]);
                    end
                end
            end
        end
    end

    // Caller must be at a negedge. Returns at the negedge after the response
    // cycle, with the request still driven (so it can be chained).
    task automatic issue(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit scramble);
        bit   bad;
        int   idx;
        int   nst;
        exp_t e;
        bad = (addr[1:0] != 2'b00) || (rd && wr);
        idx = int'(addr >> 2) % DEPTH;
        if (bad) begin
            e = '{kind: K_ERR, data: 32'h0};
        end else if (wr) begin
            mdl[d][idx] = data;
            e = '{kind: K_WR, data: data};
        end else begin
            e = '{kind: K_RD, data: mdl[d][idx]};
        end
        q[d].push_back(e);
        rr[d] = rd;
        rw[d] = wr;
        ra[d] = addr;
        wd[d] = data;
        nst = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!stl[d]) break;
            nst++;
            if (scramble && nst > 1) begin
                ra[d] = $urandom;
                wd[d] = $urandom;
            end
            @(negedge clk);
        end
        check($sformatf("stall_len_dut%0d", d), 32'(nst), bad ? 32'd0 : 32'(lat[d]));
        @(negedge clk);
    endtask

    task automatic idle(input int d, input int n);
        rr[d] = 1'b0;
        rw[d] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          k;
        lat[0] = 2;
        lat[1] = 1;
        lat[2] = 5;
        for (int d = 0; d < NDUT; d++) begin
            rr[d] = 1'b0;
            rw[d] = 1'b0;
            ra[d] = '0;
            wd[d] = '0;
            last[d] = '0;
            for (int w = 0; w < DEPTH; w++) mdl[d][w] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_stall_dut%0d", d), 32'(stl[d]), 32'd0);
            check($sformatf("rst_rdata_dut%0d", d), rdat[d], 32'd0);
            check($sformatf("rst_pulses_dut%0d", d), {29'd0, rv[d], wdn[d], er[d]}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Give every word a known value through the normal store path.
        for (int d = 0; d < NDUT; d++) begin
            for (int w = 0; w < DEPTH; w++) begin
                issue(d, 1'b0, 1'b1, 32'(w * 4), 32'h0, 1'b0);
                idle(d, 0);
            end
        end

        // Basic store then load.
        issue(0, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0); idle(0, 1);
        issue(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);        idle(0, 1);

        // Rejected requests leave the array and rdata alone.
        issue(0, 1'b0, 1'b1, 32'h10, 32'h0BADF00D, 1'b0); idle(0, 0);
        issue(0, 1'b1, 1'b0, 32'h6, 32'h0, 1'b0);         idle(0, 1);
        issue(0, 1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0); idle(0, 1);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);        idle(0, 1);

        // Address wrap modulo DEPTH*4.
        issue(0, 1'b0, 1'b1, 32'h100, 32'h11, 1'b0); idle(0, 0);
        issue(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);    idle(0, 0);
        issue(0, 1'b0, 1'b1, 32'hFC, 32'h22, 1'b0);  idle(0, 0);
        issue(0, 1'b1, 1'b0, 32'h1FC, 32'h0, 1'b0);  idle(0, 1);

        // Single-cycle and long latency, inputs disturbed while waiting.
        issue(1, 1'b0, 1'b1, 32'h40, 32'hA5A5_0001, 1'b0); idle(1, 0);
        issue(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);         idle(1, 1);
        issue(2, 1'b0, 1'b1, 32'h44, 32'hC3C3_0002, 1'b1); idle(2, 0);
        issue(2, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1);         idle(2, 1);

        // Reset in the middle of a store: stall drops at once, store is lost.
        rr[0] = 1'b0; rw[0] = 1'b1; ra[0] = 32'h20; wd[0] = 32'h55;
        #1 check("wr_stall_idle", 32'(stl[0]), 32'd1);
        @(negedge clk);
        #1 check("wr_stall_wait", 32'(stl[0]), 32'd1);
        rst_n = 1'b0;
        #1 check("stall_async_drop", 32'(stl[0]), 32'd0);
        idle(0, 0);
        for (int d = 0; d < NDUT; d++) last[d] = '0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) check($sformatf("midrst_rdata_dut%0d", d), rdat[d], 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0); idle(0, 1);

        // Back-to-back loads with req_read held high throughout.
        issue(0, 1'b0, 1'b1, 32'h0, 32'h1111_AAAA, 1'b0); idle(0, 0);
        issue(0, 1'b0, 1'b1, 32'h4, 32'h2222_BBBB, 1'b0); idle(0, 0);
        issue(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        issue(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        idle(0, 1);

        // Randomized traffic on every latency variant.
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 40; n++) begin
                k = $urandom_range(0, 9);
                a = $urandom;
                if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
                issue(d, (k < 5) || (k == 9), k >= 5, a, $urandom, 1'b1);
                idle(d, $urandom_range(0, 2));
            end
        end

        repeat (5) @(negedge clk);
        for (int d = 0; d < NDUT; d++) check($sformatf("drained_dut%0d", d), 32'(q[d].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
